fp_add_sequencer: RTL and testbench

FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

---
 rtl/fp_add_sequencer_pkg.sv | 33 +++
 rtl/fp_issue_fifo.sv | 46 ++++
 rtl/fp_add_sequencer.sv | 128 ++++++++++++
 tb/tb_fp_add_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_sequencer_pkg.sv
// Shared types and constants for the FP add/sub sequencer: FSM states, op
// encodings, the sign-bit index and the issue FIFO entry layout.
package fp_add_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAUNCH,
        WAIT,
        WB
    } state_t;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;
    localparam int   SIGN_BIT = 31;
    localparam int   ENTRY_W  = 16;

    typedef struct packed {
        logic       op;
        logic [4:0] fs;
        logic [4:0] ft;
        logic [4:0] fd;
    } issue_entry_t;

    // Subtraction is an addition with source B negated.
    function automatic logic [31:0] apply_op(input logic op, input logic [31:0] b);
        logic [31:0] r;
        r = b;
        if (op == OP_SUB) r[SIGN_BIT] = ~b[SIGN_BIT];
        return r;
    endfunction

endpackage

// File: rtl/fp_issue_fifo.sv
// Issue FIFO for the FP add sequencer; DEPTH must be a power of two, at least 2.
// Push while full and pop while empty are ignored.
module fp_issue_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Sequences queued add.s/sub.s instructions: register read, adder launch,
// bounded wait for the result and a single register-file writeback.
module fp_add_sequencer
    import fp_add_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int QDEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic        issue_op,
    input  logic [4:0]  issue_fs,
    input  logic [4:0]  issue_ft,
    input  logic [4:0]  issue_fd,
    output logic [4:0]  rf_addr_a,
    output logic [4:0]  rf_addr_b,
    input  logic [31:0] rf_data_a,
    input  logic [31:0] rf_data_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_start,
    input  logic        add_done,
    input  logic [31:0] add_result,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout_err
);
    localparam int          CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    issue_entry_t       entry_q;
    issue_entry_t       push_entry;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [31:0]        add_a_q, add_b_q, result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               timeout_hit;

    assign push_entry = '{op: issue_op, fs: issue_fs, ft: issue_ft, fd: issue_fd};

    fp_issue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_valid),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A late add_done on the terminal WAIT cycle still counts as completion.
    assign timeout_hit = (state_q == WAIT) && !add_done && (cnt_q == LAST_CNT);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        add_start = 1'b0;
        wb_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = READ;
                end
            end
            READ:   state_d = LAUNCH;
            LAUNCH: begin
                add_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (add_done)         state_d = WB;
                else if (timeout_hit) state_d = IDLE;
            end
            WB: begin
                wb_en   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) entry_q <= issue_entry_t'(fifo_dout);
            if (state_q == READ) begin
                add_a_q <= rf_data_a;
                add_b_q <= apply_op(entry_q.op, rf_data_b);
            end
            if (state_q == LAUNCH)    cnt_q <= '0;
            else if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == WAIT && add_done) result_q <= add_result;
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign issue_ready = !fifo_full;
    assign rf_addr_a   = entry_q.fs;
    assign rf_addr_b   = entry_q.ft;
    assign add_a       = add_a_q;
    assign add_b       = add_b_q;
    assign wb_addr     = entry_q.fd;
    assign wb_data     = result_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer: bench-side register file, adder
// stand-in, directed vector table, multi-cycle corner sequences and random traffic.
module tb_fp_add_sequencer;
    localparam int TIMEOUT_CYC = 64;
    localparam int QDEPTH      = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_op = 1'b0;
    logic [4:0]  issue_fs = '0, issue_ft = '0, issue_fd = '0;
    logic        issue_ready;
    logic [4:0]  rf_addr_a, rf_addr_b;
    logic [31:0] rf_data_a, rf_data_b;
    logic [31:0] add_a, add_b;
    logic        add_start;
    logic        add_done = 1'b0;
    logic [31:0] add_result = '0;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy, timeout_err;

    fp_add_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .add_a(add_a), .add_b(add_b), .add_start(add_start),
        .add_done(add_done), .add_result(add_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rf [32];
    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    typedef struct { logic op; logic [4:0] fs, ft, fd; } instr_t;
    typedef struct {
        logic op; logic [4:0] fs, ft, fd;
        logic [31:0] a, b; int lat;
        logic [31:0] exp_add_b, exp_res; int exp_lat;
    } vec_t;

    instr_t      sb[$];
    logic [31:0] model_rf [32];
    int          checks = 0, errors = 0;
    int          pend = 0, cur_lat = 5, wb_count = 0;
    bit          mute = 0, kick = 0, start_fire = 0, wb_fire = 0;
    logic [31:0] cap_a = '0, cap_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact IEEE sums for the directed cases; any other pair gets an integer sum,
    // which is fine because the sequencer never looks at operand values.
    function automatic logic [31:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        if (a == 32'h40400000 && b == 32'h40400000) return 32'h40C00000;
        return a + b;
    endfunction

    function automatic logic [31:0] operand_b(input instr_t i);
        logic [31:0] v;
        v = model_rf[i.ft];
        if (i.op) v = {~v[31], v[30:0]};
        return v;
    endfunction

    task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
        rf[idx]       = val;
        model_rf[idx] = val;
    endtask

    // In-order reference: the oldest accepted instruction is always the one in flight.
    task automatic monitor();
        logic [31:0] exp;
        start_fire = add_start;
        wb_fire    = wb_en;
        if (add_start) begin
            check("launch_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                check("launch_add_a", add_a, model_rf[sb[0].fs]);
                check("launch_add_b", add_b, operand_b(sb[0]));
            end
        end
        if (wb_en) begin
            wb_count++;
            check("wb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp = fake_add(model_rf[sb[0].fs], operand_b(sb[0]));
                check("wb_addr", 32'(wb_addr), 32'(sb[0].fd));
                check("wb_data", wb_data, exp);
                model_rf[sb[0].fd] = exp;
                void'(sb.pop_front());
            end
            rf[wb_addr] = wb_data;
        end
    endtask

    task automatic adder();
        add_done = 1'b0;
        if (!rst) begin
            pend = 0;
            return;
        end
        if (kick) begin
            add_done   = 1'b1;
            add_result = 32'hDEADBEEF;
            kick       = 0;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                add_done   = 1'b1;
                add_result = fake_add(cap_a, cap_b);
                check("hold_add_a", add_a, cap_a);
                check("hold_add_b", add_b, cap_b);
            end
        end
        if (add_start && !mute) begin
            pend  = cur_lat;
            cap_a = add_a;
            cap_b = add_b;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst) monitor();
        else begin
            start_fire = 0;
            wb_fire    = 0;
        end
        adder();
    endtask

    task automatic issue(input logic op, input logic [4:0] fs, input logic [4:0] ft,
                         input logic [4:0] fd, output bit acc);
        instr_t e;
        issue_valid = 1'b1;
        issue_op = op; issue_fs = fs; issue_ft = ft; issue_fd = fd;
        acc = issue_ready;
        if (acc) begin
            e = '{op, fs, ft, fd};
            sb.push_back(e);
        end
        step();
        issue_valid = 1'b0;
    endtask

    task automatic wait_flag(input bit want_wb, input int budget, input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(want_wb ? wb_fire : start_fire) && n < budget);
        check(name, 32'(want_wb ? wb_fire : start_fire), 1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || sb.size() != 0 || pend != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_busy", 32'(busy), 0);
        check("drain_queue", 32'(sb.size()), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(issue_ready), 1);
        check({tag, "_add_start"}, 32'(add_start), 0);
        check({tag, "_wb_en"}, 32'(wb_en), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check({tag, "_add_a"}, add_a, 0);
        check({tag, "_add_b"}, add_b, 0);
        check({tag, "_wb_addr"}, 32'(wb_addr), 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_rf_addr_a"}, 32'(rf_addr_a), 0);
        check({tag, "_rf_addr_b"}, 32'(rf_addr_b), 0);
    endtask

    initial begin
        vec_t vecs[5];
        bit   acc;
        int   t0, s, wb0, n, tries;

        vecs[0] = '{1'b0, 5'd1, 5'd2, 5'd3,  32'h3F800000, 32'h40000000, 5,  32'h40000000, 32'h40400000, 9};
        vecs[1] = '{1'b1, 5'd1, 5'd2, 5'd3,  32'h40400000, 32'h3F800000, 5,  32'hBF800000, 32'h40000000, 9};
        vecs[2] = '{1'b1, 5'd5, 5'd6, 5'd7,  32'h12345678, 32'h80000001, 3,  32'h00000001, 32'h12345679, 7};
        vecs[3] = '{1'b0, 5'd0, 5'd0, 5'd31, 32'h00000005, 32'h00000005, 1,  32'h00000005, 32'h0000000A, 5};
        vecs[4] = '{1'b0, 5'd8, 5'd9, 5'd10, 32'h00000001, 32'h00000002, 64, 32'h00000002, 32'h00000003, 68};

        for (int i = 0; i < 32; i++) set_reg(5'(i), 32'h0);

        step();
        step();
        check_reset("reset");
        rst = 1'b1;
        step();

        // Directed vectors: operands, sign flip, latency (incl. done on terminal count).
        for (int i = 0; i < 5; i++) begin
            set_reg(vecs[i].fs, vecs[i].a);
            set_reg(vecs[i].ft, vecs[i].b);
            cur_lat = vecs[i].lat;
            t0 = cyc;
            issue(vecs[i].op, vecs[i].fs, vecs[i].ft, vecs[i].fd, acc);
            check("vec_accept", 32'(acc), 1);
            n = 0;
            do begin
                step();
                n++;
                if (start_fire) begin
                    check("vec_add_a", add_a, vecs[i].a);
                    check("vec_add_b", add_b, vecs[i].exp_add_b);
                end
            end while (!wb_fire && n < 200);
            check("vec_wb_seen", 32'(wb_fire), 1);
            check("vec_wb_addr", 32'(wb_addr), 32'(vecs[i].fd));
            check("vec_wb_data", wb_data, vecs[i].exp_res);
            check("vec_latency", 32'(cyc - t0), 32'(vecs[i].exp_lat));
            drain(300);
        end

        // Back-to-back RAW chain: f3 = f1 + f2, then f4 = f3 + f3.
        set_reg(5'd1, 32'h3F800000);
        set_reg(5'd2, 32'h40000000);
        cur_lat = 5;
        wb0 = wb_count;
        issue(1'b0, 5'd1, 5'd2, 5'd3, acc);
        check("raw_accept0", 32'(acc), 1);
        issue(1'b0, 5'd3, 5'd3, 5'd4, acc);
        check("raw_accept1", 32'(acc), 1);
        drain(300);
        check("raw_wb_count", 32'(wb_count - wb0), 2);
        check("raw_f3", rf[3], 32'h40400000);
        check("raw_f4", rf[4], 32'h40C00000);

        // FIFO full while the FSM is stalled in WAIT.
        set_reg(5'd1, 32'h00000011);
        set_reg(5'd2, 32'h00000022);
        cur_lat = 30;
        wb0 = wb_count;
        issue(1'b0, 5'd1, 5'd2, 5'd16, acc);
        wait_flag(1'b0, 20, "full_launch");
        cur_lat = 3;
        issue(1'b1, 5'd1, 5'd2, 5'd17, acc);
        check("full_accept1", 32'(acc), 1);
        issue(1'b0, 5'd2, 5'd1, 5'd18, acc);
        check("full_accept2", 32'(acc), 1);
        check("full_ready_low", 32'(issue_ready), 0);
        issue(1'b0, 5'd1, 5'd1, 5'd20, acc);
        check("full_drop", 32'(acc), 0);
        wait_flag(1'b1, 100, "full_wb0");
        check("full_ready_wb", 32'(issue_ready), 0);
        step();
        check("full_ready_idle", 32'(issue_ready), 0);
        step();
        check("full_ready_back", 32'(issue_ready), 1);
        drain(300);
        check("full_wb_count", 32'(wb_count - wb0), 3);

        // Timeout: first entry never completes, the queued one still proceeds.
        mute = 1;
        wb0 = wb_count;
        issue(1'b0, 5'd1, 5'd2, 5'd11, acc);
        issue(1'b0, 5'd1, 5'd2, 5'd12, acc);
        wait_flag(1'b0, 20, "to_launch");
        s = cyc;
        for (int i = 0; i < TIMEOUT_CYC; i++) step();
        check("to_err_before", 32'(timeout_err), 0);
        step();
        check("to_err_set", 32'(timeout_err), 1);
        void'(sb.pop_front());
        mute = 0;
        step();
        step();
        check("to_next_launch", 32'(start_fire), 1);
        check("to_next_cycle", 32'(cyc - s), 32'(TIMEOUT_CYC + 3));
        drain(300);
        check("to_wb_count", 32'(wb_count - wb0), 1);
        check("to_err_sticky", 32'(timeout_err), 1);

        // Reset while waiting on the adder; a stray add_done afterwards is ignored.
        cur_lat = 20;
        issue(1'b0, 5'd1, 5'd2, 5'd13, acc);
        issue(1'b0, 5'd1, 5'd2, 5'd14, acc);
        wait_flag(1'b0, 20, "rst_launch");
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        check_reset("rst_mid");
        step();
        step();
        check_reset("rst_hold");
        rst = 1'b1;
        sb.delete();
        wb0 = wb_count;
        step();
        step();
        kick = 1;
        for (int i = 0; i < 30; i++) step();
        check("rst_no_wb", 32'(wb_count - wb0), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(issue_ready), 1);

        cur_lat = 2;
        issue(1'b1, 5'd1, 5'd2, 5'd15, acc);
        check("resume_accept", 32'(acc), 1);
        drain(300);
        check("resume_wb_count", 32'(wb_count - wb0), 1);

        // Random traffic against the in-order reference.
        for (int i = 0; i < 32; i++) set_reg(5'(i), $urandom);
        wb0 = wb_count;
        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(0, 2));
            for (int g = 0; g < n; g++) step();
            cur_lat = int'($urandom_range(1, 8));
            tries = 0;
            do begin
                issue(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), acc);
                tries++;
            end while (!acc && tries < 100);
            check("rand_accept", 32'(acc), 1);
        end
        drain(3000);
        check("rand_wb_count", 32'(wb_count - wb0), 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
